// File: rtl/request_unit_ctrl.sv
// Memory request unit: holds dmem read/write requests until dhit, gates instruction fetch,
// parks the CPU on halt and trips a sticky watchdog when dhit never arrives.
module request_unit_ctrl #(
    parameter int MAX_WAIT    = 64,
    parameter bit CONC_IFETCH = 1'b0,
    localparam int CNT_W      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             halt,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             imemREN,
    output logic             dpending,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             timeout,
    output logic             conflict
);

    // state  | meaning
    // IDLE   | fetching, waiting for a load/store or halt
    // DREQ   | data request held until dhit or watchdog expiry
    // HALTED | parked after halt, terminal until nRST
    // TOUT   | watchdog expired, terminal until nRST
    typedef enum logic [1:0] {IDLE, DREQ, HALTED, TOUT} state_t;

    // With the watchdog disabled the counter still runs and saturates at 1.
    localparam logic [CNT_W-1:0] SAT_CNT  = (MAX_WAIT == 0) ? CNT_W'(1) : CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] LAST_CNT = (MAX_WAIT == 0) ? '0 : CNT_W'(MAX_WAIT - 1);
    localparam bit               WD_EN    = (MAX_WAIT != 0);

    state_t state;
    logic   halt_pend;
    logic   wd_expire;

    assign wd_expire = WD_EN && (wait_cnt == LAST_CNT);
    assign imemREN   = (state == IDLE) || ((state == DREQ) && CONC_IFETCH);
    assign dpending  = (state == DREQ);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            wait_cnt  <= '0;
            timeout   <= 1'b0;
            conflict  <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            conflict <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (ihit && (memRead || memWrite)) begin
                        state     <= DREQ;
                        dmemWEN   <= memWrite;
                        dmemREN   <= memRead & ~memWrite;
                        wait_cnt  <= '0;
                        conflict  <= memRead & memWrite;
                        halt_pend <= 1'b0;
                    end
                end
                DREQ: begin
                    if (dhit) begin
                        dmemREN  <= 1'b0;
                        dmemWEN  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= (halt_pend || halt) ? HALTED : IDLE;
                    end else begin
                        halt_pend <= halt_pend | halt;
                        if (wait_cnt != SAT_CNT)
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wd_expire) begin
                            state   <= TOUT;
                            dmemREN <= 1'b0;
                            dmemWEN <= 1'b0;
                            timeout <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                end
                TOUT: begin
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                    timeout <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_request_unit_ctrl.sv
// Directed bench for request_unit_ctrl: three instances (default, concurrent fetch,
// short watchdog) share one stimulus stream; expected values are hand-derived.
module tb_request_unit_ctrl;

    logic CLK = 1'b0;
    logic nRST, ihit, dhit, memRead, memWrite, halt;

    logic       a_ren, a_wen, a_iren, a_dpend, a_tout, a_conf;
    logic [6:0] a_cnt;
    logic       b_ren, b_wen, b_iren, b_dpend, b_tout, b_conf;
    logic [6:0] b_cnt;
    logic       c_ren, c_wen, c_iren, c_dpend, c_tout, c_conf;
    logic [2:0] c_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 CLK = ~CLK;

    request_unit_ctrl #(.MAX_WAIT(64), .CONC_IFETCH(1'b0)) dut_a (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memRead(memRead),
        .memWrite(memWrite), .halt(halt), .dmemREN(a_ren), .dmemWEN(a_wen),
        .imemREN(a_iren), .dpending(a_dpend), .wait_cnt(a_cnt), .timeout(a_tout),
        .conflict(a_conf));

    request_unit_ctrl #(.MAX_WAIT(64), .CONC_IFETCH(1'b1)) dut_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memRead(memRead),
        .memWrite(memWrite), .halt(halt), .dmemREN(b_ren), .dmemWEN(b_wen),
        .imemREN(b_iren), .dpending(b_dpend), .wait_cnt(b_cnt), .timeout(b_tout),
        .conflict(b_conf));

    request_unit_ctrl #(.MAX_WAIT(4), .CONC_IFETCH(1'b0)) dut_c (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memRead(memRead),
        .memWrite(memWrite), .halt(halt), .dmemREN(c_ren), .dmemWEN(c_wen),
        .imemREN(c_iren), .dpending(c_dpend), .wait_cnt(c_cnt), .timeout(c_tout),
        .conflict(c_conf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        ihit = 0; dhit = 0; memRead = 0; memWrite = 0; halt = 0;
    endtask

    task automatic do_reset();
        idle_in();
        nRST = 0;
        step();
        nRST = 1;
        step();
    endtask

    initial begin
        idle_in();
        nRST = 0;
        #12;
        chk("rst_dmemREN", a_ren, 0);
        chk("rst_dmemWEN", a_wen, 0);
        chk("rst_imemREN", a_iren, 1);
        chk("rst_dpending", a_dpend, 0);
        chk("rst_wait_cnt", a_cnt, 0);
        chk("rst_timeout", a_tout, 0);
        chk("rst_conflict", a_conf, 0);
        nRST = 1;
        step();

        // 1: load, dhit on the fourth request cycle
        ihit = 1; memRead = 1;
        step();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            chk("ld_dmemREN", a_ren, 1);
            chk("ld_dmemWEN", a_wen, 0);
            chk("ld_imemREN", a_iren, 0);
            chk("ld_dpending", a_dpend, 1);
            chk("ld_wait_cnt", a_cnt, i);
            if (i == 3) dhit = 1;
            step();
        end
        idle_in();
        chk("ld_done_dmemREN", a_ren, 0);
        chk("ld_done_wait_cnt", a_cnt, 0);
        chk("ld_done_imemREN", a_iren, 1);
        chk("ld_done_dpending", a_dpend, 0);

        // 5: read and write together -> write wins, one-cycle conflict
        ihit = 1; memRead = 1; memWrite = 1;
        step();
        idle_in();
        chk("cf_dmemWEN", a_wen, 1);
        chk("cf_dmemREN", a_ren, 0);
        chk("cf_conflict", a_conf, 1);
        step();
        chk("cf_conflict_drop", a_conf, 0);
        chk("cf_dmemWEN_held", a_wen, 1);
        dhit = 1;
        step();
        idle_in();
        chk("cf_done_dmemWEN", a_wen, 0);

        // 2: store with concurrent fetch; a new ihit/load is ignored
        ihit = 1; memWrite = 1;
        step();
        idle_in();
        chk("cc_dmemWEN", b_wen, 1);
        chk("cc_imemREN", b_iren, 1);
        chk("cc_stall_imemREN", a_iren, 0);
        ihit = 1; memRead = 1;
        step();
        idle_in();
        chk("cc_ign_dmemWEN", b_wen, 1);
        chk("cc_ign_dmemREN", b_ren, 0);
        chk("cc_ign_imemREN", b_iren, 1);
        chk("cc_ign_wait_cnt", b_cnt, 1);
        dhit = 1;
        step();
        idle_in();
        chk("cc_done_dmemWEN", b_wen, 0);
        chk("cc_done_dpending", b_dpend, 0);

        // 3: watchdog with MAX_WAIT=4 and no dhit
        do_reset();
        ihit = 1; memRead = 1;
        step();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            chk("wd_dmemREN", c_ren, 1);
            chk("wd_timeout_low", c_tout, 0);
            chk("wd_wait_cnt", c_cnt, i);
            step();
        end
        chk("wd_timeout", c_tout, 1);
        chk("wd_dmemREN_drop", c_ren, 0);
        chk("wd_imemREN", c_iren, 0);
        chk("wd_dpending", c_dpend, 0);
        chk("wd_long_no_timeout", a_tout, 0);
        chk("wd_long_wait_cnt", a_cnt, 4);
        ihit = 1; memRead = 1;
        step(); step();
        idle_in();
        chk("wd_sticky_timeout", c_tout, 1);
        chk("wd_sticky_dmemREN", c_ren, 0);
        nRST = 0;
        #1;
        chk("wd_rst_timeout", c_tout, 0);
        step();
        nRST = 1;
        step();

        // dhit on the expiry cycle wins over the watchdog
        ihit = 1; memRead = 1;
        step();
        idle_in();
        step(); step(); step();
        chk("wd_edge_wait_cnt", c_cnt, 3);
        dhit = 1;
        step();
        idle_in();
        chk("wd_edge_timeout", c_tout, 0);
        chk("wd_edge_imemREN", c_iren, 1);
        chk("wd_edge_dpending", c_dpend, 0);

        // 4: halt during DREQ holds the request, then parks
        ihit = 1; memRead = 1;
        step();
        idle_in();
        halt = 1;
        step();
        halt = 0;
        chk("hp_dmemREN_held", a_ren, 1);
        chk("hp_dpending", a_dpend, 1);
        step();
        dhit = 1;
        step();
        idle_in();
        chk("hp_halted_imemREN", a_iren, 0);
        chk("hp_halted_dmemREN", a_ren, 0);
        chk("hp_halted_dpending", a_dpend, 0);
        ihit = 1; memWrite = 1;
        step();
        idle_in();
        chk("hp_terminal_dmemWEN", a_wen, 0);
        chk("hp_terminal_imemREN", a_iren, 0);

        // halt in IDLE beats a simultaneous load
        do_reset();
        halt = 1; ihit = 1; memRead = 1;
        step();
        idle_in();
        chk("hi_imemREN", a_iren, 0);
        chk("hi_dmemREN", a_ren, 0);
        chk("hi_dpending", a_dpend, 0);

        // 6: async reset mid-request
        do_reset();
        ihit = 1; memRead = 1;
        step();
        idle_in();
        chk("ar_dmemREN_pre", a_ren, 1);
        #2;
        nRST = 0;
        #1;
        chk("ar_dmemREN_async", a_ren, 0);
        chk("ar_imemREN_async", a_iren, 1);
        chk("ar_dpending_async", a_dpend, 0);
        step();
        nRST = 1;
        step(); step();
        chk("ar_post_dmemREN", a_ren, 0);
        chk("ar_post_imemREN", a_iren, 1);
        chk("ar_post_timeout", a_tout, 0);
        chk("ar_post_wait_cnt", a_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
